cam_capture: RTL

- Pixel-capture engine directly upstream of the Wishbone camera frame buffer.
- Drives the camera XCLK and samples the OV7670-style parallel bus (PCLK/VSYNC/HREF/D[7:0]) inside the system clock domain.
- Packs RGB565 byte pairs into RGB332 bytes and writes one frame into the buffer RAM write port.
- Uses a start/done handshake that maps onto the new_foto/ok_foto control bits.

---
 rtl/cam_pkg.sv | 26 ++
 rtl/cam_sync.sv | 61 ++++++
 rtl/cam_capture.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera capture engine.
//   cam_state_t       capture FSM states
//   CAM_*             default geometry / clocking constants
//   rgb565_to_rgb332  packs an RGB565 byte pair into one RGB332 byte
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cam_state_t;

    localparam int unsigned CAM_H_ACT    = 160;
    localparam int unsigned CAM_V_ACT    = 120;
    localparam int unsigned CAM_AW       = 15;
    localparam int unsigned CAM_XCLK_DIV = 2;

    // byte0 = {R[4:0], G[5:3]}, byte1 = {G[2:0], B[4:0]}
    // result = {R[4:2], G[5:3], B[4:3]}
    function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] byte0,
                                                     input logic [7:0] byte1);
        return {byte0[7:5], byte0[2:0], byte1[4:3]};
    endfunction

endpackage

// File: rtl/cam_sync.sv
// cam_sync: brings the camera bus into the clk domain.
//   clk, reset          system clock, async active-low reset
//   pclk, vsync, href   raw camera control pins
//   data                raw camera pixel byte
//   pclk_rise           one-cycle pulse per PCLK rising edge
//   vs_rise, vs_fall    one-cycle pulses on VSYNC edges
//   href_lvl, href_fall synchronised HREF level and falling-edge pulse
//   data_q              pixel byte, aligned with the pulses above
// All four inputs go through two flops, then one registered edge-detect
// stage; data and href level are delayed by the same stage so they stay
// aligned with the edge pulses.
module cam_sync #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pclk,
    input  logic          vsync,
    input  logic          href,
    input  logic [DW-1:0] data,
    output logic          pclk_rise,
    output logic          vs_rise,
    output logic          vs_fall,
    output logic          href_lvl,
    output logic          href_fall,
    output logic [DW-1:0] data_q
);

    // bit order: {pclk, vsync, href}
    logic [2:0]    meta, sync, prev;
    logic [DW-1:0] data_m, data_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta      <= '0;
            sync      <= '0;
            prev      <= '0;
            data_m    <= '0;
            data_s    <= '0;
            data_q    <= '0;
            pclk_rise <= 1'b0;
            vs_rise   <= 1'b0;
            vs_fall   <= 1'b0;
            href_lvl  <= 1'b0;
            href_fall <= 1'b0;
        end else begin
            meta      <= {pclk, vsync, href};
            sync      <= meta;
            prev      <= sync;
            data_m    <= data;
            data_s    <= data_m;
            data_q    <= data_s;
            pclk_rise <= sync[2] & ~prev[2];
            vs_rise   <= sync[1] & ~prev[1];
            vs_fall   <= ~sync[1] & prev[1];
            href_lvl  <= sync[0];
            href_fall <= ~sync[0] & prev[0];
        end
    end

endmodule

// File: rtl/cam_capture.sv
// cam_capture: captures one OV7670-style RGB565 frame into the frame buffer
// as RGB332 bytes.
//   clk, reset     system clock, async active-low reset
//   start          one-cycle capture request (ignored while busy)
//   cam_xclk       camera master clock, clk/(2*XCLK_DIV)
//   cam_pclk/cam_vsync/cam_href/cam_data  camera parallel bus (async)
//   busy, done     capture in progress / frame complete (held until start)
//   frame_err      frame ended before V_ACT lines; valid with done
//   mem_we/mem_addr/mem_wdata  buffer write port, addr = row*H_ACT+col
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned H_ACT    = CAM_H_ACT,
    parameter int unsigned V_ACT    = CAM_V_ACT,
    parameter int unsigned AW       = CAM_AW,
    parameter int unsigned XCLK_DIV = CAM_XCLK_DIV
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          cam_xclk,
    input  logic          cam_pclk,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    output logic          busy,
    output logic          done,
    output logic          frame_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata
);

    localparam int unsigned CW = $clog2(H_ACT + 1);
    localparam int unsigned RW = $clog2(V_ACT + 1);
    localparam int unsigned XW = $clog2(XCLK_DIV + 1);

    logic          pclk_rise, vs_rise, vs_fall, href_lvl, href_fall;
    logic [7:0]    data_q;

    cam_state_t    state_q, state_d;
    logic          start_ok, end_short;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          phase;
    logic [AW-1:0] line_base;
    logic [7:0]    byte0;
    logic [XW-1:0] xcnt;

    cam_sync #(
        .DW(8)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .pclk      (cam_pclk),
        .vsync     (cam_vsync),
        .href      (cam_href),
        .data      (cam_data),
        .pclk_rise (pclk_rise),
        .vs_rise   (vs_rise),
        .vs_fall   (vs_fall),
        .href_lvl  (href_lvl),
        .href_fall (href_fall),
        .data_q    (data_q)
    );

    // Free-running XCLK divider, independent of capture state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xcnt     <= '0;
            cam_xclk <= 1'b0;
        end else if (xcnt == XW'(XCLK_DIV - 1)) begin
            xcnt     <= '0;
            cam_xclk <= ~cam_xclk;
        end else begin
            xcnt <= xcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        end_short = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = WAIT_VS;
                    start_ok = 1'b1;
                end
            end
            WAIT_VS: begin
                if (vs_fall) state_d = CAPTURE;
            end
            CAPTURE: begin
                // vs_rise wins over a coincident href fall
                if (vs_rise) begin
                    state_d   = DONE;
                    end_short = 1'b1;
                end else if (href_fall && row == RW'(V_ACT - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            row       <= '0;
            col       <= '0;
            phase     <= 1'b0;
            line_base <= '0;
            byte0     <= '0;
        end else begin
            mem_we <= 1'b0;
            busy   <= (state_d == WAIT_VS) || (state_d == CAPTURE);
            done   <= (state_d == DONE);

            if (start_ok) begin
                frame_err <= 1'b0;
                row       <= '0;
                col       <= '0;
                phase     <= 1'b0;
                line_base <= '0;
                byte0     <= '0;
            end

            if (end_short) frame_err <= 1'b1;

            if (state_q == CAPTURE && !vs_rise) begin
                if (href_fall) begin
                    // line base tracks row*H_ACT by accumulation
                    row       <= row + 1'b1;
                    col       <= '0;
                    phase     <= 1'b0;
                    line_base <= line_base + AW'(H_ACT);
                end else if (pclk_rise && href_lvl) begin
                    phase <= ~phase;
                    if (!phase) begin
                        byte0 <= data_q;
                    end else if (col < CW'(H_ACT)) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= line_base + AW'(col);
                        mem_wdata <= rgb565_to_rgb332(byte0, data_q);
                        col       <= col + 1'b1;
                    end
                end
            end
        end
    end

endmodule
